// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg : shared encodings and widths for the write-back stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    SEL_ALU   = 2'b00,
    SEL_SHIFT = 2'b01,
    SEL_HI    = 2'b10,
    SEL_LO    = 2'b11
  } super_sel_e;

endpackage

`default_nettype wire

// File: rtl/wb_stage_hilo_reg.sv
// ---------------------------------------------------------------------------
// hilo_reg : 64-bit load-enabled HI/LO register pair, async active-low reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_reg
  import wb_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [2*DATA_W-1:0] d,
  output logic [DATA_W-1:0]   hi_q,
  output logic [DATA_W-1:0]   lo_q
);

  logic [2*DATA_W-1:0] hilo_q;
  logic [2*DATA_W-1:0] hilo_d;

  always_comb begin
    hilo_d = hilo_q;
    if (load) begin
      hilo_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  assign hi_q = hilo_q[2*DATA_W-1:DATA_W];
  assign lo_q = hilo_q[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage : pipeline write-back stage -- result mux, link write, PC
//            redirect, HI/LO register and retired-write counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              multu_enW,
  input  logic              jr_selW,
  input  logic [1:0]        super_selW,
  input  logic              dm2regW,
  input  logic              jumpW,
  input  logic              jal_selW,
  input  logic              we_regW,
  input  logic [31:0]       pc_plus_4W,
  input  logic [31:0]       alu_paW,
  input  logic [63:0]       alu_outW,
  input  logic [31:0]       rd_dmW,
  input  logic [31:0]       shiftyW,
  input  logic [31:0]       jtaW,
  input  logic [4:0]        rf_waW,
  input  logic              cnt_clr,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [31:0]       rf_wd,
  output logic              pc_redir,
  output logic [31:0]       pc_target,
  output logic [31:0]       hi_q,
  output logic [31:0]       lo_q,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [DATA_W-1:0] sel_wd;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (multu_enW),
    .d     (alu_outW),
    .hi_q  (hi_q),
    .lo_q  (lo_q)
  );

  // mfhi/mflo read the registered pair; no bypass of a same-cycle multu
  always_comb begin
    sel_wd = '0;
    case (super_sel_e'(super_selW))
      SEL_ALU:   sel_wd = dm2regW ? rd_dmW : alu_outW[DATA_W-1:0];
      SEL_SHIFT: sel_wd = shiftyW;
      SEL_HI:    sel_wd = hi_q;
      SEL_LO:    sel_wd = lo_q;
      default:   sel_wd = '0;
    endcase
  end

  always_comb begin
    rf_we = we_regW;
    rf_wa = rf_waW;
    rf_wd = sel_wd;
    if (jal_selW) begin
      rf_we = 1'b1;
      rf_wa = LINK_REG;
      rf_wd = pc_plus_4W;
    end
  end

  always_comb begin
    pc_redir  = jr_selW | jumpW;
    pc_target = '0;
    if (jr_selW) begin
      pc_target = alu_paW;
    end else if (jumpW) begin
      pc_target = jtaW;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;

endmodule

`default_nettype wire
